scan_seq_2bit: RTL and testbench
================================

SCAN_SEQ_2BIT -- requirements
Module: scan_seq_2bit

Interface
REQ-001 Parameter: DIV, 4, clock cycles per scan slot; legal range 2..256.
REQ-002 Parameter: BLANK, 1, leading cycles of each slot with en=0; legal range 1..DIV-1.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  level-sampled request to begin continuous scanning.
REQ-006 Port: stop  input  1  level-sampled request to end scanning at the next slot boundary.
REQ-007 Port: step  input  1  request for one single-slot advance while idle.
REQ-008 Port: dir  input  1  scan direction; 0 = up (00->01->10->11), 1 = down.
REQ-009 Port: a  output  1  MSB of current code; drives the 2-to-4 decoder a input.
REQ-010 Port: b  output  1  LSB of current code; drives the decoder b input.
REQ-011 Port: en  output  1  decoder enable; high only during the display part of a slot.
REQ-012 Port: busy  output  1  high whenever the state is not IDLE.
REQ-013 Port: sweep_done  output  1  one-cycle pulse at the end of the last slot of a full 4-code sweep.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, BLANK, SHOW; all outputs are registered.
REQ-015 A slot SHALL last DIV cycles: BLANK cycles in BLANK (en=0), then DIV-BLANK cycles in SHOW (en=1); {a,b} is constant for the whole slot.
REQ-016 IDLE: en=0, busy=0, code held; start=1 (with stop=0) SHALL load code 00 (dir=0) or 11 (dir=1), clear the prescaler, and enter BLANK next cycle.
REQ-017 IDLE: step=1 (with start=0 and stop=0) SHALL advance the code by one in the dir direction (modulo 4), set the single flag, and enter BLANK.
REQ-018 IDLE: simultaneous start and stop SHALL leave the block in IDLE; simultaneous start and step SHALL behave as start.
REQ-019 BLANK SHALL move to SHOW after BLANK cycles; SHOW SHALL end the slot after DIV-BLANK cycles.
REQ-020 At slot end: if the single flag is set or stop is latched, go to IDLE, clear both flags, and hold the code; otherwise advance the code modulo 4 per dir and enter BLANK.
REQ-021 stop asserted in BLANK or SHOW SHALL be latched and never truncate the current slot; start and step SHALL be ignored outside IDLE.
REQ-022 dir SHALL be sampled only at slot end (and at start/step in IDLE); changes mid-slot have no effect on the current slot.
REQ-023 Wrap-around: 11+1 = 00 and 00-1 = 11.
REQ-024 sweep_done SHALL pulse for exactly one cycle, coincident with the first cycle after a continuous-mode slot ends whose code was 11 (dir=0) or 00 (dir=1); single-step slots never pulse it.
REQ-025 The prescaler width SHALL be ceil(log2(DIV)); it SHALL never exceed DIV-1.

Reset
REQ-026 While rst=1: state=IDLE, a=0, b=0, en=0, busy=0, sweep_done=0, prescaler=0, stop and single flags cleared.
REQ-027 rst SHALL override all other inputs, including mid-slot; after rst falls, the block remains in IDLE until a new start or step.

Verification
REQ-028 DIV=4, BLANK=1; reset, then start pulse at cycle 0 -> busy=1 from cycle 1; {a,b}=00,01,10,11 in 4-cycle slots; en=0 at cycles 1,5,9,13 and en=1 otherwise; sweep_done=1 at cycle 17 only; scanning continues.
REQ-029 dir=1, start -> codes 11,10,01,00; sweep_done pulses after the 00 slot.
REQ-030 Running; stop pulsed in the 2nd SHOW cycle of code 01 -> 01 slot completes in full, then IDLE with {a,b}=01 held, en=0, busy=0, no sweep_done.
REQ-031 Idle at code 11, step pulse with dir=0 -> {a,b}=00, one slot (en low 1 cycle, high 3 cycles), then IDLE; sweep_done stays 0.
REQ-032 start and stop high in the same IDLE cycle -> remains IDLE, busy=0; rst asserted in SHOW mid-sweep -> next cycle all outputs 0, IDLE.

Source files
------------

// File: rtl/scan_seq_2bit.sv
// scan_seq_2bit: 2-bit scan sequencer for a 2-to-4 decoder.
// Each scan slot lasts DIV cycles: BLANK cycles with the decoder disabled,
// then DIV-BLANK cycles with it enabled. The code on {a,b} is stable for the
// whole slot. The sequencer runs continuously after start, or for a single
// slot after step, and ends at a slot boundary when stop is requested.
module scan_seq_2bit #(
  parameter int DIV   = 4,
  parameter int BLANK = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stop,
  input  logic step,
  input  logic dir,
  output logic a,
  output logic b,
  output logic en,
  output logic busy,
  output logic sweep_done
);

  // Slot prescaler spans the whole slot: 0..DIV-1.
  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    code_q, code_d;
  logic          single_q, single_d;
  logic          stop_q, stop_d;
  logic          dir_q, dir_d;      // direction in force for the current slot
  logic          en_q, busy_q, sweep_q, sweep_d;
  logic          stop_seen;

  // Code advance by one position in the requested direction, modulo 4.
  function automatic logic [1:0] next_code(input logic [1:0] c, input logic d);
    return d ? (c - 2'd1) : (c + 2'd1);
  endfunction

  // Next-state logic: slot sequencing, code advance and flag handling.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    single_d  = single_q;
    stop_d    = stop_q;
    dir_d     = dir_q;
    sweep_d   = 1'b0;
    // A stop seen in the final cycle of a slot still ends scanning there.
    stop_seen = stop_q | stop;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d  = S_BLANK;
          code_d   = dir ? 2'b11 : 2'b00;
          cnt_d    = '0;
          single_d = 1'b0;
          stop_d   = 1'b0;
          dir_d    = dir;
        end else if (step && !start && !stop) begin
          state_d  = S_BLANK;
          code_d   = next_code(code_q, dir);
          cnt_d    = '0;
          single_d = 1'b1;
          stop_d   = 1'b0;
          dir_d    = dir;
        end
      end

      S_BLANK: begin
        stop_d = stop_seen;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == BLANK_LAST) begin
          state_d = S_SHOW;
        end
      end

      S_SHOW: begin
        stop_d = stop_seen;
        if (cnt_q == SLOT_LAST) begin
          cnt_d   = '0;
          // Last code of a sweep in the slot's own direction.
          sweep_d = !single_q && (code_q == (dir_q ? 2'b00 : 2'b11));
          if (single_q || stop_seen) begin
            state_d  = S_IDLE;
            single_d = 1'b0;
            stop_d   = 1'b0;
          end else begin
            state_d = S_BLANK;
            code_d  = next_code(code_q, dir);
            dir_d   = dir;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; outputs are derived from the next state so
  // they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      code_q   <= 2'b00;
      single_q <= 1'b0;
      stop_q   <= 1'b0;
      dir_q    <= 1'b0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      sweep_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      single_q <= single_d;
      stop_q   <= stop_d;
      dir_q    <= dir_d;
      en_q     <= (state_d == S_SHOW);
      busy_q   <= (state_d != S_IDLE);
      sweep_q  <= sweep_d;
    end
  end

  assign a          = code_q[1];
  assign b          = code_q[0];
  assign en         = en_q;
  assign busy       = busy_q;
  assign sweep_done = sweep_q;

endmodule

// File: tb/tb_scan_seq_2bit.sv
// Testbench for scan_seq_2bit: directed scenarios with literal expectations
// plus randomized stimulus compared every cycle against a slot-level model.
module tb_scan_seq_2bit;

  localparam int DIV   = 4;
  localparam int BLANK = 1;

  logic clk = 1'b0;
  logic rst, start, stop, step, dir;
  logic a, b, en, busy, sweep_done;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 1'b0;

  scan_seq_2bit #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step), .dir(dir),
    .a(a), .b(b), .en(en), .busy(busy), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  // Reference model: running flag, code, position within slot.
  bit       m_busy = 1'b0;
  bit [1:0] m_code = 2'b00;
  int       m_pos  = 0;
  bit       m_single = 1'b0;
  bit       m_stop = 1'b0;
  bit       m_dir  = 1'b0;
  bit       m_sd   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_code = 0; m_pos = 0; m_single = 0; m_stop = 0; m_sd = 0; m_dir = 0;
    end else begin
      m_sd = 0;
      if (!m_busy) begin
        if (start && !stop) begin
          m_busy = 1; m_code = dir ? 2'd3 : 2'd0; m_pos = 0;
          m_single = 0; m_stop = 0; m_dir = dir;
        end else if (step && !start && !stop) begin
          m_busy = 1; m_code = 2'((int'(m_code) + (dir ? 3 : 1)) % 4); m_pos = 0;
          m_single = 1; m_stop = 0; m_dir = dir;
        end
      end else begin
        if (stop) m_stop = 1;
        if (m_pos == DIV - 1) begin
          m_pos = 0;
          if (!m_single && m_code == (m_dir ? 2'd0 : 2'd3)) m_sd = 1;
          if (m_single || m_stop) begin
            m_busy = 0; m_single = 0; m_stop = 0;
          end else begin
            m_code = 2'((int'(m_code) + (dir ? 3 : 1)) % 4);
            m_dir  = dir;
          end
        end else begin
          m_pos++;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [4:0] exp_v, act_v;
    if (cmp_en) begin
      exp_v = {m_code, (m_busy && m_pos >= BLANK), m_busy, m_sd};
      act_v = {a, b, en, busy, sweep_done};
      n_checks++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL model_cmp t=%0t {a,b,en,busy,sd} actual=%b required=%b", $time, act_v, exp_v);
      end
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Full sweep from start; k counts cycles after the start-sampling edge.
  task automatic run_sweep(input bit d);
    int slot;
    logic [1:0] exp_code;
    dir = d; start = 1; tick(); start = 0;
    for (int k = 1; k <= 20; k++) begin
      slot = ((k - 1) / 4) % 4;
      exp_code = d ? 2'(3 - slot) : 2'(slot);
      chk("sweep_code", {2'b00, a, b}, {2'b00, exp_code});
      chk("sweep_en", {3'b0, en}, {3'b0, ((k - 1) % 4) != 0});
      chk("sweep_done", {3'b0, sweep_done}, {3'b0, k == 17});
      $display("sweep dir=%0d cycle=%0d code=%b en=%b busy=%b sd=%b", d, k, {a, b}, en, busy, sweep_done);
      tick();
    end
  endtask

  task automatic do_step(input bit d);
    dir = d; step = 1; tick(); step = 0;
    repeat (5) tick();
    $display("step dir=%0d -> code=%b busy=%b", d, {a, b}, busy);
  endtask

  initial begin
    rst = 1; start = 0; stop = 0; step = 0; dir = 0;
    repeat (3) tick();
    cmp_en = 1;
    chk("reset_outs", {1'b0, a, b, en}, 4'h0);
    chk("reset_flags", {2'b0, busy, sweep_done}, 4'h0);
    rst = 0; tick();

    // Continuous up sweep, then stop in the 2nd SHOW cycle of code 01.
    run_sweep(1'b0);                       // now at cycle 21: code 01, blank
    chk("stop_pre_code", {2'b0, a, b}, 4'h1);
    tick(); tick();                         // cycle 23: 2nd SHOW of 01
    stop = 1; tick(); stop = 0;             // cycle 24: slot still running
    chk("stop_slot_full", {1'b0, a, b, en}, 4'h3);
    chk("stop_busy", {3'b0, busy}, 4'h1);
    tick();                                 // cycle 25: idle
    chk("stop_idle_code", {2'b0, a, b}, 4'h1);
    chk("stop_idle_flags", {1'b0, en, busy, sweep_done}, 4'h0);
    repeat (3) tick();
    chk("stop_stays_idle", {1'b0, busy, a, b}, 4'h1);
    $display("stop test: code=%b busy=%b", {a, b}, busy);

    // Step down twice (01 -> 00 -> 11), then single step up wraps to 00.
    do_step(1'b1);
    chk("step_down", {2'b0, a, b}, 4'h0);
    do_step(1'b1);
    chk("step_wrap_down", {2'b0, a, b}, 4'h3);
    dir = 0; step = 1; tick(); step = 0;
    chk("step_first", {a, b, en, busy}, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("step_show", {a, b, en, sweep_done}, 4'b0010);
    end
    tick();
    chk("step_end", {a, b, busy, sweep_done}, 4'b0000);
    chk("step_end_en", {3'b0, en}, 4'h0);
    $display("single step: code=%b busy=%b", {a, b}, busy);

    // Down sweep, then reset in the middle of a SHOW phase.
    run_sweep(1'b1);                        // cycle 21: code 10 blank
    tick();                                 // cycle 22: SHOW
    chk("pre_rst_show", {a, b, en, busy}, 4'b1011);
    rst = 1; tick();
    chk("rst_mid_outs", {1'b0, a, b, en}, 4'h0);
    chk("rst_mid_flags", {2'b0, busy, sweep_done}, 4'h0);
    rst = 0; repeat (3) tick();
    chk("rst_after_idle", {a, b, en, busy}, 4'h0);

    // start and stop together: stays idle.
    dir = 1; start = 1; stop = 1; tick(); start = 0; stop = 0;
    chk("start_stop_busy", {3'b0, busy}, 4'h0);
    chk("start_stop_code", {2'b0, a, b}, 4'h0);
    tick();
    chk("start_stop_busy2", {3'b0, busy}, 4'h0);
    // start and step together behaves as start.
    dir = 1; start = 1; step = 1; tick(); start = 0; step = 0;
    chk("start_step_code", {a, b, en, busy}, 4'b1101);
    $display("start/stop and start/step tests done");

    // Randomized phase, checked every cycle by the model comparison.
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 999) < 4);
      start = ($urandom_range(0, 99) < 6);
      stop  = ($urandom_range(0, 99) < 4);
      step  = ($urandom_range(0, 99) < 6);
      if ($urandom_range(0, 9) == 0) dir = ~dir;
      tick();
      if (n % 250 == 0)
        $display("random n=%0d code=%b en=%b busy=%b sd=%b", n, {a, b}, en, busy, sweep_done);
    end
    rst = 0; start = 0; stop = 0; step = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
